// File: rtl/dmem_arbiter.sv
// dmem_arbiter: arbitrates one synchronous data-memory port between the core MEM stage and an aux master.
// Optional statistics counters are built when DMEM_ARB_STATS_EN is defined.
`default_nettype none

module dmem_arbiter #(
  parameter int unsigned AW           = 32,
  parameter int unsigned DW           = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          rst,
`ifdef DMEM_ARB_STATS_EN
  output logic [31:0]   stat_conflicts,
  output logic [31:0]   stat_core_stalls,
  output logic [31:0]   stat_aux_grants,
`endif
  input  logic          core_req,
  input  logic          core_we,
  input  logic [AW-1:0] core_addr,
  input  logic [DW-1:0] core_wdata,
  output logic          core_gnt,
  output logic          core_stall,
  output logic          core_rvalid,
  output logic [DW-1:0] core_rdata,
  input  logic          aux_req,
  input  logic          aux_we,
  input  logic          aux_lock,
  input  logic [AW-1:0] aux_addr,
  input  logic [DW-1:0] aux_wdata,
  output logic          aux_gnt,
  output logic          aux_rvalid,
  output logic [DW-1:0] aux_rdata,
  output logic          ram_wen,
  output logic          ram_ren,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata
);

  localparam logic [3:0] c_LIMIT = 4'(STARVE_LIMIT);

  typedef enum logic [0:0] {
    ST_IDLE       = 1'b0,
    ST_AUX_LOCKED = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CORE = 2'd1,
    OWN_AUX  = 2'd2
  } owner_t;

  state_t     r_state;
  state_t     w_state_nxt;
  owner_t     r_rd_owner;
  owner_t     w_rd_owner_nxt;
  logic [3:0] r_starve_cnt;
  logic       w_core_gnt;
  logic       w_aux_gnt;
  logic       w_lock_hold;
  logic       w_we;

  // Arbitration; everything is forced idle while rst is high.
  always_comb begin
    w_core_gnt  = 1'b0;
    w_aux_gnt   = 1'b0;
    w_state_nxt = ST_IDLE;
    w_lock_hold = (r_state == ST_AUX_LOCKED) && aux_lock;
    if (!rst) begin
      if (w_lock_hold) begin
        w_aux_gnt = aux_req;
      end else begin
        w_aux_gnt  = aux_req && (!core_req || (r_starve_cnt == c_LIMIT));
        w_core_gnt = core_req && !w_aux_gnt;
      end
      if (w_lock_hold || (w_aux_gnt && aux_lock)) begin
        w_state_nxt = ST_AUX_LOCKED;
      end
    end
  end

  always_comb begin
    ram_addr       = '0;
    ram_wdata      = '0;
    w_we           = 1'b0;
    w_rd_owner_nxt = OWN_NONE;
    if (w_aux_gnt) begin
      ram_addr  = aux_addr;
      ram_wdata = aux_wdata;
      w_we      = aux_we;
      if (!aux_we) w_rd_owner_nxt = OWN_AUX;
    end else if (w_core_gnt) begin
      ram_addr  = core_addr;
      ram_wdata = core_wdata;
      w_we      = core_we;
      if (!core_we) w_rd_owner_nxt = OWN_CORE;
    end
  end

  assign ram_wen    = (w_aux_gnt || w_core_gnt) && w_we;
  assign ram_ren    = (w_aux_gnt || w_core_gnt) && !w_we;
  assign core_gnt   = w_core_gnt;
  assign aux_gnt    = w_aux_gnt;
  assign core_stall = core_req && !w_core_gnt && !rst;

  // Read data is steered by the owner captured when the read issued.
  assign core_rvalid = (r_rd_owner == OWN_CORE) && !rst;
  assign aux_rvalid  = (r_rd_owner == OWN_AUX) && !rst;
  assign core_rdata  = core_rvalid ? ram_rdata : '0;
  assign aux_rdata   = aux_rvalid ? ram_rdata : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_rd_owner   <= OWN_NONE;
      r_starve_cnt <= 4'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_rd_owner <= w_rd_owner_nxt;
      if (w_aux_gnt) begin
        r_starve_cnt <= 4'd0;
      end else if (aux_req && (r_starve_cnt != c_LIMIT)) begin
        r_starve_cnt <= r_starve_cnt + 4'd1;
      end
    end
  end

`ifdef DMEM_ARB_STATS_EN
  logic [31:0] r_stat_conflicts;
  logic [31:0] r_stat_core_stalls;
  logic [31:0] r_stat_aux_grants;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stat_conflicts   <= '0;
      r_stat_core_stalls <= '0;
      r_stat_aux_grants  <= '0;
    end else begin
      if (core_req && aux_req && (r_stat_conflicts != '1)) begin
        r_stat_conflicts <= r_stat_conflicts + 32'd1;
      end
      if (core_stall && (r_stat_core_stalls != '1)) begin
        r_stat_core_stalls <= r_stat_core_stalls + 32'd1;
      end
      if (w_aux_gnt && (r_stat_aux_grants != '1)) begin
        r_stat_aux_grants <= r_stat_aux_grants + 32'd1;
      end
    end
  end

  assign stat_conflicts   = r_stat_conflicts;
  assign stat_core_stalls = r_stat_core_stalls;
  assign stat_aux_grants  = r_stat_aux_grants;
`endif

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed stimulus with a per-cycle reference model of dmem_arbiter plus literal spot checks.
`default_nettype none

module tb_dmem_arbiter;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        core_req, core_we, aux_req, aux_we, aux_lock;
  logic [31:0] core_addr, core_wdata, aux_addr, aux_wdata;
  logic        core_gnt, core_stall, core_rvalid, aux_gnt, aux_rvalid;
  logic [31:0] core_rdata, aux_rdata;
  logic        ram_wen, ram_ren;
  logic [31:0] ram_addr, ram_wdata, ram_rdata;
`ifdef DMEM_ARB_STATS_EN
  logic [31:0] stat_conflicts, stat_core_stalls, stat_aux_grants;
`endif

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.AW(32), .DW(32), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
`ifdef DMEM_ARB_STATS_EN
    .stat_conflicts(stat_conflicts), .stat_core_stalls(stat_core_stalls),
    .stat_aux_grants(stat_aux_grants),
`endif
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_gnt(core_gnt), .core_stall(core_stall), .core_rvalid(core_rvalid),
    .core_rdata(core_rdata),
    .aux_req(aux_req), .aux_we(aux_we), .aux_lock(aux_lock), .aux_addr(aux_addr),
    .aux_wdata(aux_wdata), .aux_gnt(aux_gnt), .aux_rvalid(aux_rvalid), .aux_rdata(aux_rdata),
    .ram_wen(ram_wen), .ram_ren(ram_ren), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  // Synchronous RAM seen by the arbiter: one-cycle read latency.
  logic [31:0] ram_mem [256];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) ram_mem[i] <= 32'h0;
      ram_mem[0] <= 32'h11111111;
      ram_mem[1] <= 32'h22222222;
      ram_mem[4] <= 32'hDEADBEEF;
      ram_rdata  <= 32'h0;
    end else begin
      if (ram_wen) ram_mem[ram_addr[9:2]] <= ram_wdata;
      if (ram_ren) ram_rdata <= ram_mem[ram_addr[9:2]];
    end
  end

  // Reference model: memory image, starvation count, lock flag, pending read.
  logic [31:0] ref_mem [256];
  int          m_starve;
  bit          m_locked;
  int          m_pend;       // 0 none, 1 core, 2 aux
  logic [31:0] m_pend_data;
  int          m_conf, m_stall, m_auxg;

  function automatic void model_grants(output logic cg, output logic ag);
    if (m_locked && aux_lock) begin
      ag = aux_req;
      cg = 1'b0;
    end else begin
      ag = aux_req && (!core_req || m_starve >= LIMIT);
      cg = core_req && !ag;
    end
  endfunction

  always @(posedge clk) begin
    logic cg, ag, we;
    logic [31:0] a, d;
    model_grants(cg, ag);
    if (rst) begin
      for (int i = 0; i < 256; i++) ref_mem[i] <= 32'h0;
      ref_mem[0] <= 32'h11111111;
      ref_mem[1] <= 32'h22222222;
      ref_mem[4] <= 32'hDEADBEEF;
      m_starve <= 0; m_locked <= 1'b0; m_pend <= 0; m_pend_data <= 32'h0;
      m_conf <= 0; m_stall <= 0; m_auxg <= 0;
    end else begin
      we = ag ? aux_we : core_we;
      a  = ag ? aux_addr : core_addr;
      d  = ag ? aux_wdata : core_wdata;
      if ((ag || cg) && we) ref_mem[a[9:2]] <= d;
      m_pend      <= ((ag || cg) && !we) ? (ag ? 2 : 1) : 0;
      m_pend_data <= ref_mem[a[9:2]];
      if (ag) m_starve <= 0;
      else if (aux_req && m_starve < LIMIT) m_starve <= m_starve + 1;
      m_locked <= aux_lock && ((m_locked && aux_lock) || ag);
      if (core_req && aux_req) m_conf <= m_conf + 1;
      if (core_req && !cg) m_stall <= m_stall + 1;
      if (ag) m_auxg <= m_auxg + 1;
    end
  end

  // Every-cycle comparison against the model, mid-cycle.
  always @(negedge clk) begin
    logic cg, ag, we;
    logic [31:0] a, d;
    model_grants(cg, ag);
    if (rst) begin
      cg = 1'b0; ag = 1'b0;
    end
    we = ag ? aux_we : (cg ? core_we : 1'b0);
    a  = ag ? aux_addr : (cg ? core_addr : 32'h0);
    d  = ag ? aux_wdata : (cg ? core_wdata : 32'h0);
    chk1("core_gnt", core_gnt, cg);
    chk1("aux_gnt", aux_gnt, ag);
    chk1("core_stall", core_stall, !rst && core_req && !cg);
    chk1("ram_wen", ram_wen, (ag || cg) && we);
    chk1("ram_ren", ram_ren, (ag || cg) && !we);
    chk("ram_addr", ram_addr, a);
    chk("ram_wdata", ram_wdata, d);
    chk1("core_rvalid", core_rvalid, !rst && m_pend == 1);
    chk1("aux_rvalid", aux_rvalid, !rst && m_pend == 2);
    chk("core_rdata", core_rdata, (!rst && m_pend == 1) ? m_pend_data : 32'h0);
    chk("aux_rdata", aux_rdata, (!rst && m_pend == 2) ? m_pend_data : 32'h0);
  end

  task automatic apply(input logic r,
                       input logic cr, input logic cwe, input logic [31:0] ca, input logic [31:0] cwd,
                       input logic ar, input logic awe, input logic al,
                       input logic [31:0] aa, input logic [31:0] awd);
    @(posedge clk);
    #1;
    rst = r;
    core_req = cr; core_we = cwe; core_addr = ca; core_wdata = cwd;
    aux_req = ar; aux_we = awe; aux_lock = al; aux_addr = aa; aux_wdata = awd;
    @(negedge clk);
  endtask

  task automatic idle();
    apply(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    int beat, consec, tries;
`ifdef DMEM_ARB_STATS_EN
    logic [31:0] s_conf, s_stall, s_auxg;
`endif
    rst = 1'b1;
    core_req = 1'b0; core_we = 1'b0; core_addr = 32'h0; core_wdata = 32'h0;
    aux_req = 1'b0; aux_we = 1'b0; aux_lock = 1'b0; aux_addr = 32'h0; aux_wdata = 32'h0;

    // Reset holds every output low even with requests present.
    apply(1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 1'b0, 32'h4, 32'h0);
    chk1("rst_core_gnt", core_gnt, 1'b0);
    chk1("rst_core_stall", core_stall, 1'b0);
    apply(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

    // Core-only read of 0x10.
    apply(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk1("cread_gnt", core_gnt, 1'b1);
    chk1("cread_ren", ram_ren, 1'b1);
    chk("cread_addr", ram_addr, 32'h10);
    idle();
    chk1("cread_rvalid", core_rvalid, 1'b1);
    chk("cread_rdata", core_rdata, 32'hDEADBEEF);
    chk1("cread_aux_rvalid", aux_rvalid, 1'b0);

    // Continuous conflict: aux wins every fifth cycle.
`ifdef DMEM_ARB_STATS_EN
    s_conf = stat_conflicts; s_stall = stat_core_stalls; s_auxg = stat_aux_grants;
`endif
    for (int k = 0; k < 10; k++) begin
      apply(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h4, 32'h0);
      chk1("conflict_aux_gnt", aux_gnt, (k == 4 || k == 9));
      chk1("conflict_core_gnt", core_gnt, !(k == 4 || k == 9));
    end
    idle();
`ifdef DMEM_ARB_STATS_EN
    chk("stat_conflicts_delta", stat_conflicts - s_conf, 32'd10);
    chk("stat_core_stalls_delta", stat_core_stalls - s_stall, 32'd2);
    chk("stat_aux_grants_delta", stat_aux_grants - s_auxg, 32'd2);
`endif

    // Locked aux burst of 8 writes against a persistent core request.
    beat = 0; consec = 0; tries = 0;
    while (beat < 8 && tries < 40) begin
      apply(1'b0, 1'b1, 1'b0, 32'h200, 32'h0, 1'b1, 1'b1, 1'b1,
            32'h100 + 32'(beat * 4), 32'(beat + 1));
      tries++;
      if (aux_gnt) begin
        beat++; consec++;
      end else begin
        consec = 0;
      end
    end
    chk("burst_beats", 32'(beat), 32'd8);
    chk("burst_consecutive", 32'(consec), 32'd8);
    apply(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk1("unlock_core_gnt", core_gnt, 1'b1);

    // Read the burst back, pipelined.
    for (int i = 0; i <= 8; i++) begin
      apply(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, (i < 8), 1'b0, 1'b0, 32'h100 + 32'(i * 4), 32'h0);
      if (i > 0) begin
        chk1("readback_rvalid", aux_rvalid, 1'b1);
        chk("readback_data", aux_rdata, 32'(i));
      end
    end

    // Alternating owners on successive cycles.
    apply(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    apply(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h4, 32'h0);
    chk1("alt_core_rvalid", core_rvalid, 1'b1);
    chk("alt_core_rdata", core_rdata, 32'h11111111);
    chk1("alt_aux_rvalid0", aux_rvalid, 1'b0);
    apply(1'b0, 1'b1, 1'b1, 32'h8, 32'hCAFEF00D, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk1("alt_aux_rvalid", aux_rvalid, 1'b1);
    chk("alt_aux_rdata", aux_rdata, 32'h22222222);
    chk1("alt_core_rvalid0", core_rvalid, 1'b0);
    chk1("alt_write_wen", ram_wen, 1'b1);

    // Reset the cycle after a locked aux read grant.
    apply(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h4, 32'h0);
    chk1("rstmid_aux_gnt", aux_gnt, 1'b1);
    apply(1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 1'b1, 32'h4, 32'h0);
    chk1("rstmid_aux_rvalid", aux_rvalid, 1'b0);
    chk1("rstmid_aux_gnt0", aux_gnt, 1'b0);
    chk("rstmid_aux_rdata", aux_rdata, 32'h0);
    apply(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 1'b1, 32'h4, 32'h0);
    chk1("post_rst_core_gnt", core_gnt, 1'b1);
    chk1("post_rst_aux_gnt", aux_gnt, 1'b0);
    idle();
    idle();

`ifdef DMEM_ARB_STATS_EN
    chk("stat_conflicts", stat_conflicts, 32'(m_conf));
    chk("stat_core_stalls", stat_core_stalls, 32'(m_stall));
    chk("stat_aux_grants", stat_aux_grants, 32'(m_auxg));
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
